// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start validation,
// centre sampling of data bits and stop-bit framing check.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Rx_Serial,
    output logic                  o_Rx_DV,
    output logic [DATA_WIDTH-1:0] o_Rx_Byte,
    output logic                  o_Rx_Busy,
    output logic                  o_Rx_Frame_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] TOP  = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    logic                  r_Rx_Meta;
    logic                  r_Rx_Sync;
    state_t                r_State;
    logic [CW-1:0]         r_Count;
    logic [IW-1:0]         r_Index;
    logic [DATA_WIDTH-1:0] r_Shift;
    logic [DATA_WIDTH-1:0] r_Rx_Byte;
    logic                  r_Rx_DV;
    logic                  r_Frame_Err;

    state_t                w_State;
    logic [CW-1:0]         w_Count;
    logic [IW-1:0]         w_Index;
    logic [DATA_WIDTH-1:0] w_Shift;
    logic [DATA_WIDTH-1:0] w_Rx_Byte;
    logic                  w_Rx_DV;
    logic                  w_Frame_Err;

    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Rx_Meta <= 1'b1;
            r_Rx_Sync <= 1'b1;
        end else begin
            r_Rx_Meta <= i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State     <= S_IDLE;
            r_Count     <= '0;
            r_Index     <= '0;
            r_Shift     <= '0;
            r_Rx_Byte   <= '0;
            r_Rx_DV     <= 1'b0;
            r_Frame_Err <= 1'b0;
        end else begin
            r_State     <= w_State;
            r_Count     <= w_Count;
            r_Index     <= w_Index;
            r_Shift     <= w_Shift;
            r_Rx_Byte   <= w_Rx_Byte;
            r_Rx_DV     <= w_Rx_DV;
            r_Frame_Err <= w_Frame_Err;
        end
    end

    always_comb begin
        w_State     = r_State;
        w_Count     = r_Count;
        w_Index     = r_Index;
        w_Shift     = r_Shift;
        w_Rx_Byte   = r_Rx_Byte;
        w_Rx_DV     = 1'b0;
        w_Frame_Err = 1'b0;
        unique case (r_State)
            S_IDLE: begin
                w_Count = '0;
                w_Index = '0;
                if (!r_Rx_Sync) begin
                    w_State = S_START;
                end
            end
            S_START: begin
                if (r_Count < HALF) begin
                    w_Count = r_Count + 1'b1;
                end else begin
                    w_Count = '0;
                    // A line back high at mid-start is a glitch.
                    w_State = r_Rx_Sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_Count < LAST) begin
                    w_Count = r_Count + 1'b1;
                end else begin
                    w_Count          = '0;
                    w_Shift[r_Index] = r_Rx_Sync;
                    if (r_Index < TOP) begin
                        w_Index = r_Index + 1'b1;
                    end else begin
                        w_Index = '0;
                        w_State = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_Count < LAST) begin
                    w_Count = r_Count + 1'b1;
                end else begin
                    w_Count = '0;
                    w_State = S_CLEANUP;
                    if (r_Rx_Sync) begin
                        w_Rx_Byte = r_Shift;
                        w_Rx_DV   = 1'b1;
                    end else begin
                        w_Frame_Err = 1'b1;
                    end
                end
            end
            S_CLEANUP: begin
                w_State = S_IDLE;
            end
            default: begin
                w_State = S_IDLE;
            end
        endcase
    end

    assign o_Rx_DV        = r_Rx_DV;
    assign o_Rx_Byte      = r_Rx_Byte;
    assign o_Rx_Frame_Err = r_Frame_Err;
    assign o_Rx_Busy      = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a timing-rule model over the recorded
// line history plus a byte scoreboard and literal timing pins.
module tb_uart_rx;

    localparam int C = 87;
    localparam int H = (C - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       dv;
    logic       fe;
    logic       busy;
    logic [7:0] rx_byte;

    uart_rx #(
        .CLKS_PER_BIT(C),
        .DATA_WIDTH  (8)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_Rx_Serial   (rx_line),
        .o_Rx_DV       (dv),
        .o_Rx_Byte     (rx_byte),
        .o_Rx_Busy     (busy),
        .o_Rx_Frame_Err(fe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Line value seen at every rising edge, indexed by edge number.
    logic line_h [4096];

    function automatic logic ln(input int k);
        return line_h[k % 4096];
    endfunction

    // Expected outputs after each edge, derived from the frame timing:
    // the FSM acts at edge k on the line value captured at edge k-2.
    int         t0 = -1;
    int         srch = 0;
    logic       m_dv = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] m_byte = 8'h00;

    initial begin
        logic [7:0] b;
        int n;
        forever begin
            @(posedge clk);
            cyc++;
            n = cyc;
            line_h[n % 4096] = rx_line;
            if (!rst_n) begin
                t0 = -1;
                srch = n + 1;
                m_dv = 1'b0;
                m_fe = 1'b0;
                m_busy = 1'b0;
                m_byte = 8'h00;
            end else begin
                m_dv = 1'b0;
                m_fe = 1'b0;
                if (t0 >= 0) begin
                    m_busy = (n >= t0 + 2);
                    if (n == t0 + 3 + H && ln(t0 + 1 + H)) begin
                        m_busy = 1'b0;
                        srch = t0 + 2 + H;
                        t0 = -1;
                    end else if (n == t0 + 3 + H + 9 * C) begin
                        for (int i = 0; i < 8; i++)
                            b[i] = ln(t0 + 1 + H + (i + 1) * C);
                        if (ln(t0 + 1 + H + 9 * C)) begin
                            m_dv = 1'b1;
                            m_byte = b;
                        end else begin
                            m_fe = 1'b1;
                        end
                        srch = n;
                        t0 = -1;
                    end
                end else begin
                    m_busy = 1'b0;
                end
                if (t0 < 0) begin
                    for (int k = srch; k <= n; k++) begin
                        if (!ln(k)) begin
                            t0 = k;
                            break;
                        end
                    end
                    if (t0 < 0) srch = n + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_dv", dv, 0);
                chk("rst_fe", fe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_byte", rx_byte, 0);
            end else begin
                chk("dv", dv, m_dv);
                chk("frame_err", fe, m_fe);
                chk("busy", busy, m_busy);
                chk("byte", rx_byte, m_byte);
            end
        end
    end

    // Scoreboard of bytes actually transmitted.
    logic [7:0] sent_q[$];
    int         dv_edges[$];
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         fe_exp = 0;
    int         busy_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (fe) fe_cnt++;
            if (dv) begin
                dv_cnt++;
                dv_edges.push_back(cyc);
                if (sent_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_extra: got %0h want none", rx_byte);
                end else begin
                    chk("sb_byte", rx_byte, sent_q.pop_front());
                end
            end
        end
    end

    function automatic int edge_at(input int i);
        return (i < dv_edges.size()) ? dv_edges[i] : -1;
    endfunction

    logic abort_tx = 1'b0;
    int   t0_drv = 0;

    task automatic idle(input int nc);
        repeat (nc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int per);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t0_drv = cyc + 1;
        if (stop) sent_q.push_back(b);
        else fe_exp++;
        for (int k = 0; k < 10; k++) begin
            rx_line = bits[k];
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                if (abort_tx) begin
                    rx_line = 1'b1;
                    if (stop) void'(sent_q.pop_back());
                    else fe_exp--;
                    return;
                end
            end
        end
        rx_line = 1'b1;
    endtask

    initial begin
        int a5_t0;
        int r;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_dv", dv, 0);
        chk("init_byte", rx_byte, 0);
        chk("init_busy", busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        idle(20);

        send_frame(8'hA5, 1'b1, C);
        a5_t0 = t0_drv;
        idle(100);
        chk("a5_count", dv_cnt, 1);
        chk("a5_byte", rx_byte, 8'hA5);
        chk("a5_edge", edge_at(0) - a5_t0, 829);
        chk("a5_fe", fe_cnt, 0);

        busy_cnt = 0;
        rx_line = 1'b0;
        idle(20);
        rx_line = 1'b1;
        idle(100);
        chk("glitch_busy", busy_cnt, 44);
        chk("glitch_dv", dv_cnt, 1);
        chk("glitch_fe", fe_cnt, 0);

        send_frame(8'h3C, 1'b0, C);
        idle(200);
        chk("bad_fe", fe_cnt, 1);
        chk("bad_byte", rx_byte, 8'hA5);
        chk("bad_dv", dv_cnt, 1);

        send_frame(8'h00, 1'b1, C);
        send_frame(8'hFF, 1'b1, C);
        send_frame(8'h81, 1'b1, C);
        idle(100);
        chk("b2b_count", dv_cnt, 4);
        chk("b2b_gap1", edge_at(2) - edge_at(1), 870);
        chk("b2b_gap2", edge_at(3) - edge_at(2), 870);
        chk("b2b_last", rx_byte, 8'h81);

        fork
            send_frame(8'hC3, 1'b1, C);
            begin
                idle(C + 4 * C + 40);
                chk("mid_busy", busy, 1);
                abort_tx = 1'b1;
                #1 rst_n = 1'b0;
                #1;
                chk("arst_busy", busy, 0);
                chk("arst_byte", rx_byte, 0);
                chk("arst_dv", dv, 0);
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        join
        abort_tx = 1'b0;
        @(negedge clk);
        idle(20);
        chk("arst_nostrobe", dv_cnt, 4);
        send_frame(8'h5A, 1'b1, C);
        idle(100);
        chk("post_rst_byte", rx_byte, 8'h5A);
        chk("post_rst_count", dv_cnt, 5);

        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rx_line = 1'b0;
                idle($urandom_range(1, 30));
                rx_line = 1'b1;
                idle(60);
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0, C);
                idle(200);
            end else begin
                send_frame(8'($urandom), 1'b1, $urandom_range(C - 1, C + 1));
                if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 150));
            end
        end
        idle(200);
        chk("sb_left", sent_q.size(), 0);
        chk("fe_total", fe_cnt, fe_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
